// File: rtl/window_output_aligner_pkg.sv
// rtl/window_output_aligner_pkg.sv - shared defaults and helpers for the window output aligner
package window_output_aligner_pkg;

  localparam int DEFAULT_WORD_SIZE    = 16;
  localparam int DEFAULT_FRAME_WIDTH  = 640;
  localparam int DEFAULT_FRAME_HEIGHT = 480;
  localparam int COORD_WIDTH          = 11;

  // Strobes between a source pixel entering the window and its kernel result on din.
  function automatic int calc_lag(input int frame_width, input int width,
                                  input int height, input int pipe_latency);
    return (height / 2) * frame_width + width / 2 + pipe_latency;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster-order x/y counter with enable, sync clear and end-of-line/frame flags
module raster_counter
  import window_output_aligner_pkg::*;
#(
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter int W            = COORD_WIDTH
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         last_col,
  output logic         last_pixel
);

  localparam logic [W-1:0] X_MAX = W'(FRAME_WIDTH - 1);
  localparam logic [W-1:0] Y_MAX = W'(FRAME_HEIGHT - 1);

  assign last_col   = (x == X_MAX);
  assign last_pixel = last_col && (y == Y_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (last_col) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + W'(1);
      end else begin
        x <= x + W'(1);
      end
    end
  end

endmodule

// File: rtl/window_output_aligner.sv
// rtl/window_output_aligner.sv - re-labels lagged kernel results with frame coordinates,
// substitutes border pixels and drains the window/kernel pipeline at end of frame
module window_output_aligner
  import window_output_aligner_pkg::*;
#(
  parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
  parameter int FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter int FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT,
  parameter int WIDTH        = 3,
  parameter int HEIGHT       = 3,
  parameter int PIPE_LATENCY = 1,
  parameter logic [WORD_SIZE-1:0] BORDER_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [WORD_SIZE-1:0]   din,
  output logic                   pipe_en,
  output logic [WORD_SIZE-1:0]   dout,
  output logic                   valid,
  output logic [COORD_WIDTH-1:0] x,
  output logic [COORD_WIDTH-1:0] y,
  output logic                   sof,
  output logic                   eof,
  output logic                   overrun
);

  localparam int LAG   = calc_lag(FRAME_WIDTH, WIDTH, HEIGHT, PIPE_LATENCY);
  localparam int N     = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int CNT_W = $clog2(N + 1);

  localparam logic [CNT_W-1:0] LAG_LAST = CNT_W'(LAG - 1);
  localparam logic [CNT_W-1:0] SRC_LAST = CNT_W'(N - 1);

  localparam logic [COORD_WIDTH-1:0] X_LO = COORD_WIDTH'(WIDTH / 2);
  localparam logic [COORD_WIDTH-1:0] X_HI = COORD_WIDTH'(FRAME_WIDTH - WIDTH / 2);
  localparam logic [COORD_WIDTH-1:0] Y_LO = COORD_WIDTH'(HEIGHT / 2);
  localparam logic [COORD_WIDTH-1:0] Y_HI = COORD_WIDTH'(FRAME_HEIGHT - HEIGHT / 2);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         in_cnt, in_cnt_nxt;
  logic                     emit;
  logic                     frame_done;
  logic                     border;
  logic [COORD_WIDTH-1:0]   cx, cy;
  logic                     c_last_col, c_last_pixel;

  raster_counter #(
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .W            (COORD_WIDTH)
  ) u_out_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (emit),
    .clr        (frame_done),
    .x          (cx),
    .y          (cy),
    .last_col   (c_last_col),
    .last_pixel (c_last_pixel)
  );

  assign border = (cx < X_LO) || (cx >= X_HI) || (cy < Y_LO) || (cy >= Y_HI);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= FILL;
      in_cnt <= '0;
    end else begin
      state  <= state_nxt;
      in_cnt <= in_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    in_cnt_nxt = in_cnt;
    pipe_en    = 1'b0;
    emit       = 1'b0;
    frame_done = 1'b0;
    case (state)
      FILL: begin
        pipe_en = en;
        if (en) begin
          in_cnt_nxt = in_cnt + CNT_W'(1);
          // LAG == N lets the last source pixel land while still filling
          if (in_cnt == SRC_LAST)      state_nxt = FLUSH;
          else if (in_cnt == LAG_LAST) state_nxt = RUN;
        end
      end
      RUN: begin
        pipe_en = en;
        emit    = en;
        if (en) begin
          in_cnt_nxt = in_cnt + CNT_W'(1);
          if (in_cnt == SRC_LAST) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        pipe_en = 1'b1;
        emit    = 1'b1;
        if (c_last_pixel) begin
          frame_done = 1'b1;
          in_cnt_nxt = '0;
          state_nxt  = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
    if (!reset_n) pipe_en = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout    <= '0;
      valid   <= 1'b0;
      x       <= '0;
      y       <= '0;
      sof     <= 1'b0;
      eof     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid   <= emit;
      sof     <= emit && (cx == '0) && (cy == '0);
      eof     <= emit && c_last_col && c_last_pixel;
      overrun <= (state == FLUSH) && en;
      if (emit) begin
        dout <= border ? BORDER_VALUE : din;
        x    <= cx;
        y    <= cy;
      end
    end
  end

endmodule

// File: tb/tb_window_output_aligner.sv
// tb/tb_window_output_aligner.sv - self-checking bench for window_output_aligner
module tb_window_output_aligner;

  localparam int WS  = 16;
  localparam int FW  = 8;
  localparam int FH  = 6;
  localparam int N   = FW * FH;
  localparam int LAG = (3 / 2) * FW + 3 / 2 + 1;

  typedef struct {
    int n;
    int x;
    int y;
    int d;
    bit sof;
    bit eof;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          en = 1'b0;
  logic [WS-1:0] din = '0;
  logic          pipe_en;
  logic [WS-1:0] dout;
  logic          valid;
  logic [10:0]   x;
  logic [10:0]   y;
  logic          sof;
  logic          eof;
  logic          overrun;

  window_output_aligner #(
    .WORD_SIZE    (WS),
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH),
    .WIDTH        (3),
    .HEIGHT       (3),
    .PIPE_LATENCY (1),
    .BORDER_VALUE ('0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en),
    .din     (din),
    .pipe_en (pipe_en),
    .dout    (dout),
    .valid   (valid),
    .x       (x),
    .y       (y),
    .sof     (sof),
    .eof     (eof),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t e;
  int   ms = 0;
  bit   m_pe;
  bit   rec_strobe = 1'b0;
  bit   rec_ovr = 1'b0;
  int   rec_ms = 0;
  int   nvalid = 0;
  int   novr = 0;
  bit   done = 1'b0;
  int   cap_x[N], cap_y[N], cap_d[N], cap_s[N], cap_e[N];
  int   gold_x[N], gold_y[N], gold_d[N], gold_s[N], gold_e[N];
  exp_t vecs[10];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t exp_for(input int n, input int s);
    exp_t r;
    bit   b;
    r.n   = n;
    r.x   = n % FW;
    r.y   = n / FW;
    b     = (r.x < 1) || (r.x >= FW - 1) || (r.y < 1) || (r.y >= FH - 1);
    r.d   = b ? 0 : s;
    r.sof = (n == 0);
    r.eof = (n == N - 1);
    return r;
  endfunction

  // Model: strobe index per frame, flush forces a strobe every cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      ms         = 0;
      din        = '0;
      rec_strobe = 1'b0;
      rec_ovr    = 1'b0;
      sb.delete();
      chk("pipe_en_in_reset", int'(pipe_en), 0);
    end else begin
      m_pe = (ms >= N) ? 1'b1 : en;
      chk("pipe_en", int'(pipe_en), int'(m_pe));
      rec_strobe = m_pe;
      rec_ms     = ms;
      rec_ovr    = (ms >= N) && en;
      if (m_pe && ms >= LAG) sb.push_back(exp_for(ms - LAG, ms));
    end
  end

  always @(posedge clk) begin
    #1;
    chk("valid", int'(valid), int'(rec_strobe && rec_ms >= LAG));
    chk("overrun", int'(overrun), int'(rec_ovr));
    if (overrun === 1'b1) novr++;
    if (valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=valid required=no_output at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("x", int'(x), e.x);
        chk("y", int'(y), e.y);
        chk("dout", int'(dout), e.d);
        chk("sof", int'(sof), int'(e.sof));
        chk("eof", int'(eof), int'(e.eof));
        cap_x[e.n] = int'(x);
        cap_y[e.n] = int'(y);
        cap_d[e.n] = int'(dout);
        cap_s[e.n] = int'(sof);
        cap_e[e.n] = int'(eof);
        nvalid++;
        if (e.eof) done = 1'b1;
      end
    end
    if (rec_strobe) begin
      ms  = (ms == N + LAG - 1) ? 0 : ms + 1;
      din = WS'(ms);
    end
    rec_strobe = 1'b0;
    rec_ovr    = 1'b0;
  end

  task automatic run_frame(input bit gap, input bit ovr, input string tag);
    int src = 0;
    int k = 0;
    nvalid = 0;
    novr   = 0;
    done   = 1'b0;
    for (int i = 0; i < N; i++) begin
      cap_x[i] = -1; cap_y[i] = -1; cap_d[i] = -1; cap_s[i] = -1; cap_e[i] = -1;
    end
    while (src < N) begin
      en = gap ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #2;
      if (en) src++;
    end
    en = 1'b0;
    while (!done && k < 100) begin
      en = ovr && (k == 2 || k == 3);
      @(posedge clk); #2;
      k++;
    end
    en = 1'b0;
    chk({tag, "_frame_done"}, int'(done), 1);
    chk({tag, "_valid_count"}, nvalid, N);
    chk({tag, "_overrun_count"}, novr, ovr ? 2 : 0);
  endtask

  task automatic compare_gold(input string tag);
    int mism = 0;
    for (int i = 0; i < N; i++)
      if (cap_x[i] != gold_x[i] || cap_y[i] != gold_y[i] || cap_d[i] != gold_d[i] ||
          cap_s[i] != gold_s[i] || cap_e[i] != gold_e[i]) mism++;
    chk({tag, "_seq_mismatches"}, mism, 0);
  endtask

  initial begin
    // {output index, x, y, dout, sof, eof}; din carries the strobe index n+LAG
    vecs[0] = '{0,  0, 0, 0,  1'b1, 1'b0};
    vecs[1] = '{8,  0, 1, 0,  1'b0, 1'b0};
    vecs[2] = '{9,  1, 1, 19, 1'b0, 1'b0};
    vecs[3] = '{14, 6, 1, 24, 1'b0, 1'b0};
    vecs[4] = '{15, 7, 1, 0,  1'b0, 1'b0};
    vecs[5] = '{36, 4, 4, 46, 1'b0, 1'b0};
    vecs[6] = '{37, 5, 4, 47, 1'b0, 1'b0};
    vecs[7] = '{38, 6, 4, 48, 1'b0, 1'b0};
    vecs[8] = '{40, 0, 5, 0,  1'b0, 1'b0};
    vecs[9] = '{47, 7, 5, 0,  1'b0, 1'b1};

    reset_n = 1'b0;
    en      = 1'b0;
    repeat (4) begin
      @(posedge clk); #2;
      en = ~en;
    end
    #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_sof", int'(sof), 0);
    chk("rst_eof", int'(eof), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_pipe_en", int'(pipe_en), 0);
    en = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    en = 1'b1;
    #1 chk("pipe_en_follows_en_hi", int'(pipe_en), 1);
    en = 1'b0;
    #1 chk("pipe_en_follows_en_lo", int'(pipe_en), 0);
    @(posedge clk); #2;

    run_frame(1'b0, 1'b0, "gapless");
    for (int i = 0; i < N; i++) begin
      gold_x[i] = cap_x[i]; gold_y[i] = cap_y[i]; gold_d[i] = cap_d[i];
      gold_s[i] = cap_s[i]; gold_e[i] = cap_e[i];
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("tbl%0d_x", vecs[i].n), gold_x[vecs[i].n], vecs[i].x);
      chk($sformatf("tbl%0d_y", vecs[i].n), gold_y[vecs[i].n], vecs[i].y);
      chk($sformatf("tbl%0d_dout", vecs[i].n), gold_d[vecs[i].n], vecs[i].d);
      chk($sformatf("tbl%0d_sof", vecs[i].n), gold_s[vecs[i].n], int'(vecs[i].sof));
      chk($sformatf("tbl%0d_eof", vecs[i].n), gold_e[vecs[i].n], int'(vecs[i].eof));
    end

    run_frame(1'b1, 1'b0, "gapped");
    compare_gold("gapped");

    run_frame(1'b0, 1'b1, "overrun");
    compare_gold("overrun");

    for (int i = 0; i < 26; i++) begin
      en = 1'b1;
      @(posedge clk); #2;
    end
    en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_x", int'(x), 0);
    chk("midrst_y", int'(y), 0);
    chk("midrst_dout", int'(dout), 0);
    chk("midrst_pipe_en", int'(pipe_en), 0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(posedge clk); #2;

    run_frame(1'b0, 1'b0, "after_reset");
    compare_gold("after_reset");

    repeat (3) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/window_output_aligner.md
# window_output_aligner

Sink-side companion to the window generator and its kernel. The aligner consumes the kernel result stream, which lags the source raster by the window's centre offset plus kernel pipeline depth, and re-labels each result with its true frame coordinates. It replaces results whose window straddles a frame or line edge with a border value. At end of frame it drives extra pipeline strobes so the window/kernel pipeline drains the last results, then re-arms for the next frame.

## Interface
Parameters:
- WORD_SIZE, `WORD_SIZE, result word width
- FRAME_WIDTH, `FRAME_WIDTH, pixels per line
- FRAME_HEIGHT, `FRAME_HEIGHT, lines per frame
- WIDTH, 3, window width (odd)
- HEIGHT, 3, window height (odd)
- PIPE_LATENCY, 1, pipe_en strobes from window register update to matching kernel result on din
- BORDER_VALUE, 0, value substituted on border pixels

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  source pixel strobe (same signal the source drives)
- din  in  WORD_SIZE  kernel result, sampled when pipe_en=1
- pipe_en  out  1  strobe to drive window generator and kernel enables
- dout  out  WORD_SIZE  aligned result
- valid  out  1  dout/x/y valid this cycle
- x  out  11  column of dout
- y  out  11  row of dout
- sof  out  1  valid && x==0 && y==0
- eof  out  1  valid && x==FRAME_WIDTH-1 && y==FRAME_HEIGHT-1
- overrun  out  1  one-cycle pulse when en is asserted during FLUSH

## Operation
- LAG = (HEIGHT/2)*FRAME_WIDTH + WIDTH/2 + PIPE_LATENCY, in pipe_en strobes. N = FRAME_WIDTH*FRAME_HEIGHT.
- Result for centre pixel at raster index n arrives on din at the pipe_en strobe numbered n+LAG, counting from 0 per frame.
- States:
  - FILL (reset state): pipe_en=en; each strobe increments in_cnt; no output. After strobe LAG-1, go to RUN.
  - RUN: pipe_en=en; each strobe emits one output and increments in_cnt. When in_cnt reaches N (the last source pixel is accepted), go to FLUSH.
  - FLUSH: pipe_en=1 every cycle, and en is ignored. en=1 pulses overrun. Each cycle emits one output. After the output with index N-1, clear in_cnt and the output x/y, then go to FILL.
- Output counter (x,y) advances per emitted output. x wraps at FRAME_WIDTH-1 to 0 with y+1; y wraps at FRAME_HEIGHT-1.
- Border rule: if x<WIDTH/2, x>=FRAME_WIDTH-WIDTH/2, y<HEIGHT/2, or y>=FRAME_HEIGHT-HEIGHT/2, then dout=BORDER_VALUE; otherwise dout=din.
- Exactly N outputs per frame, in raster order; no output is dropped or duplicated.
- Requires LAG <= N; instances violating this are unsupported.

## Timing
- Outputs are registered: dout/valid/x/y/sof/eof update on the clk edge that samples a pipe_en strobe, so they are visible one cycle after the strobe. valid=0 otherwise.
- pipe_en is combinational from en and state, and is forced 0 while reset_n=0.
- Gaps in en during FILL/RUN only stall the block; the output sequence is identical to a gapless run.
- FLUSH lasts exactly LAG cycles. FLUSH->FILL and a new frame's first en may occur on the next cycle.
- Reset (async, any time): state=FILL, counters=0, dout=0, valid=0, x=0, y=0, sof=0, eof=0, overrun=0. The partial frame is discarded. Upstream reset is the integrator's responsibility.

## Structure
- FRAME_WIDTH, FRAME_HEIGHT and WORD_SIZE defaults come from global.vh. Add a coordinate width constant (11) there, shared with the queue ADDR_WIDTH.
- State encoding: localparams local to this block.
- One sub-module, raster_counter: x/y counter with enable, synchronous clear and async reset, reporting last_col/last_pixel. It is used for the output coordinates.

## Test plan
Configuration for all scenarios: FRAME_WIDTH=8, FRAME_HEIGHT=6, WIDTH=3, HEIGHT=3, PIPE_LATENCY=1, which gives LAG=10 and N=48. The bench model drives din = strobe index.

- Reset: hold reset_n=0 with en toggling -> all outputs 0 and pipe_en=0; release -> pipe_en follows en.
- Fill/first outputs: 48 back-to-back en -> valid=0 for strobes 0-9. One cycle after strobe 10: valid=1, x=0, y=0, sof=1, dout=0 (border). Strobe 19 -> x=1, y=1, dout=19.
- Flush: after strobe 47, pipe_en=1 for exactly 10 cycles with en=0. The final output has x=7, y=5, eof=1, dout=0. Total valid count is 48; the next frame starts in FILL.
- Gapped input: en with random idle cycles (~50%) -> dout/x/y sequence identical to the gapless run, and valid only on cycles following a strobe.
- Overrun: assert en for 2 cycles during FLUSH -> overrun pulses on those cycles, din capture and counters unaffected, eof still at output 48.
- Mid-frame reset: pulse reset_n low after strobe 25 -> outputs clear immediately. The following full frame reproduces the scenario-2 results exactly.
